// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit with store buffer, load forwarding and background drain
module mem_access_unit #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic [15:0] DataMemoryAddress,
    output logic [15:0] DataMemoryWriteData,
    output logic        DataMemoryWriteEnable,
    input  logic [15:0] DataMemoryOut,
    output logic        sb_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [15:0]   sb_addr [DEPTH];
    logic [15:0]   sb_data [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;

    logic          store_acc;
    logic          load_acc;
    logic          drain;
    logic          fwd_hit;
    logic [15:0]   fwd_data;
    logic [AW-1:0] idx;

    assign req_ready = (count != CW'(DEPTH));
    assign sb_empty  = (count == '0);
    assign store_acc = req_valid && req_ready && req_write;
    assign load_acc  = req_valid && req_ready && !req_write;
    assign drain     = !load_acc && (count != '0);

    // Walk oldest to youngest so the last match seen is the youngest store.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + AW'(i);
            if ((CW'(i) < count) && (sb_addr[idx] == req_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = sb_data[idx];
            end
        end
    end

    always_comb begin
        DataMemoryAddress     = '0;
        DataMemoryWriteData   = '0;
        DataMemoryWriteEnable = 1'b0;
        if (load_acc) begin
            DataMemoryAddress = req_addr;
        end else if (drain) begin
            DataMemoryAddress     = sb_addr[head];
            DataMemoryWriteData   = sb_data[head];
            DataMemoryWriteEnable = 1'b1;
        end
    end

    // Entry contents need no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (store_acc) begin
            sb_addr[tail] <= req_addr;
            sb_data[tail] <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= load_acc;
            if (load_acc) begin
                rsp_data <= fwd_hit ? fwd_data : DataMemoryOut;
            end
            if (store_acc) begin
                tail <= tail + AW'(1);
            end
            if (drain) begin
                head <= head + AW'(1);
            end
            if (store_acc && !drain) begin
                count <= count + CW'(1);
            end else if (drain && !store_acc) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule
